// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - exception codes, CP0 addresses, bit positions and priority resolver
package exc_ctrl_pkg;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam logic [31:0] EXCEPTTYPE_NONE         = 32'h0000_0000;
  localparam logic [31:0] EXCEPTTYPE_INTERRUPT    = 32'h0000_0001;
  localparam logic [31:0] EXCEPTTYPE_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXCEPTTYPE_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXCEPTTYPE_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXCEPTTYPE_OV           = 32'h0000_000c;
  localparam logic [31:0] EXCEPTTYPE_ERET         = 32'h0000_000e;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_IP_LO = 8;
  localparam int CAUSE_IP_HI = 15;

  // Cause bits software may write through mtc0: IP[1:0] (9:8), IV (23), WP (22)
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00c0_0300;

  // Positions inside mem_exc_flags_i = {eret, ov, trap, inst_invalid, syscall}
  localparam int FLAG_SYSCALL      = 0;
  localparam int FLAG_INST_INVALID = 1;
  localparam int FLAG_TRAP         = 2;
  localparam int FLAG_OV           = 3;
  localparam int FLAG_ERET         = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } exc_state_t;

  // Fixed priority: interrupt > syscall > inst_invalid > trap > ov > eret
  function automatic logic [31:0] resolve_exc(input logic int_pending, input logic [4:0] flags);
    logic [31:0] code;
    code = EXCEPTTYPE_NONE;
    if (int_pending)                    code = EXCEPTTYPE_INTERRUPT;
    else if (flags[FLAG_SYSCALL])       code = EXCEPTTYPE_SYSCALL;
    else if (flags[FLAG_INST_INVALID])  code = EXCEPTTYPE_INST_INVALID;
    else if (flags[FLAG_TRAP])          code = EXCEPTTYPE_TRAP;
    else if (flags[FLAG_OV])            code = EXCEPTTYPE_OV;
    else if (flags[FLAG_ERET])          code = EXCEPTTYPE_ERET;
    return code;
  endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// rtl/exc_ctrl_int_sync.sv - 6-bit two-flop synchronizer for external interrupt pins
module exc_ctrl_int_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] d,
  output logic [5:0] q
);

  logic [5:0] meta_q;
  logic [5:0] sync_q;

  // Two-stage capture of asynchronous pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 6'd0;
      sync_q <= 6'd0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - MEM-stage exception/interrupt resolver with drain FSM (option: EXC_INT_SYNC_EN)
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned DRAIN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ext_int_i,
  input  logic        timer_int_i,
  output logic [5:0]  int_o,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_exc_flags_i,
  input  logic [31:0] mem_inst_addr_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] epc_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

  exc_state_t  state_q, state_nxt;
  logic [2:0]  cnt_q, cnt_nxt;
  logic [31:0] status_eff, cause_eff, epc_eff;
  logic [31:0] resolved;
  logic [31:0] exc_type;
  logic        int_pending;
  logic [5:0]  ext_int;
  logic        unused_cp0;

`ifdef EXC_INT_SYNC_EN
  exc_ctrl_int_sync u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_int_i),
    .q   (ext_int)
  );
`else
  assign ext_int = ext_int_i;
`endif

  assign int_o = rst ? 6'd0 : {ext_int[5] | timer_int_i, ext_int[4:0]};

  // An in-flight mtc0 in WB overrides the CP0 register it targets
  assign status_eff = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_STATUS) ? wb_cp0_data_i : cp0_status_i;
  assign epc_eff    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_EPC) ? wb_cp0_data_i : cp0_epc_i;
  assign cause_eff  = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_CAUSE)
                    ? ((cp0_cause_i & ~CAUSE_WR_MASK) | (wb_cp0_data_i & CAUSE_WR_MASK))
                    : cp0_cause_i;

  assign int_pending = (|(cause_eff[CAUSE_IP_HI:CAUSE_IP_LO] & status_eff[CAUSE_IP_HI:CAUSE_IP_LO]))
                     && !status_eff[STATUS_EXL] && status_eff[STATUS_IE];

  // Bubbles never raise anything, including interrupts
  assign resolved = mem_valid_i ? resolve_exc(int_pending, mem_exc_flags_i) : EXCEPTTYPE_NONE;

  assign unused_cp0 = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};

  // State and drain counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Accept one exception in IDLE, then ignore the squashed slots while draining
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    exc_type  = EXCEPTTYPE_NONE;
    case (state_q)
      ST_IDLE: begin
        if (!rst && resolved != EXCEPTTYPE_NONE) begin
          exc_type  = resolved;
          state_nxt = ST_DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (cnt_q <= 3'd1) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt_q - 3'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  assign excepttype_o        = exc_type;
  assign flush_o             = (exc_type != EXCEPTTYPE_NONE);
  assign new_pc_o            = flush_o ? ((exc_type == EXCEPTTYPE_ERET) ? epc_eff : EXC_VECTOR) : 32'd0;
  assign busy_o              = (state_q == ST_DRAIN);
  assign epc_o               = epc_eff;
  assign current_inst_addr_o = mem_inst_addr_i;
  assign is_in_delayslot_o   = mem_in_delayslot_i;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - self-checking bench for exc_ctrl (DRAIN_CYCLES 1 and 3 instances)
module tb_exc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst3;
  logic [5:0]  ext_int;
  logic        timer_int;
  logic        mem_valid;
  logic [4:0]  flags;
  logic [31:0] inst_addr;
  logic        delayslot;
  logic [31:0] status, cause, epc;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_data;

  logic [5:0]  int_a, int_b;
  logic [31:0] type_a, type_b, cia_a, cia_b, epc_a, epc_b, npc_a, npc_b;
  logic        ds_a, ds_b, flush_a, flush_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int rem[2];
  int dcyc[2] = '{1, 3};
  logic [5:0] hist0[2];
  logic [5:0] hist1[2];

  exc_ctrl #(.EXC_VECTOR(32'h0000_0020), .DRAIN_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .ext_int_i(ext_int), .timer_int_i(timer_int), .int_o(int_a),
    .mem_valid_i(mem_valid), .mem_exc_flags_i(flags), .mem_inst_addr_i(inst_addr),
    .mem_in_delayslot_i(delayslot), .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
    .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr), .wb_cp0_data_i(wb_data),
    .excepttype_o(type_a), .current_inst_addr_o(cia_a), .is_in_delayslot_o(ds_a), .epc_o(epc_a),
    .flush_o(flush_a), .new_pc_o(npc_a), .busy_o(busy_a)
  );

  exc_ctrl #(.EXC_VECTOR(32'h0000_0020), .DRAIN_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .ext_int_i(ext_int), .timer_int_i(timer_int), .int_o(int_b),
    .mem_valid_i(mem_valid), .mem_exc_flags_i(flags), .mem_inst_addr_i(inst_addr),
    .mem_in_delayslot_i(delayslot), .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
    .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr), .wb_cp0_data_i(wb_data),
    .excepttype_o(type_b), .current_inst_addr_o(cia_b), .is_in_delayslot_o(ds_b), .epc_o(epc_b),
    .flush_o(flush_b), .new_pc_o(npc_b), .busy_o(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_epc();
    return (wb_we && wb_waddr == 5'd14) ? wb_data : epc;
  endfunction

  // Reference: what the instruction in MEM should raise, ignoring drain state
  function automatic logic [31:0] model_type();
    logic [31:0] st, cs;
    logic [31:0] codes[5];
    logic pend;
    codes = '{32'h8, 32'ha, 32'hd, 32'hc, 32'he};
    st = (wb_we && wb_waddr == 5'd12) ? wb_data : status;
    cs = cause;
    if (wb_we && wb_waddr == 5'd13) begin
      cs[9:8] = wb_data[9:8];
      cs[22]  = wb_data[22];
      cs[23]  = wb_data[23];
    end
    pend = ((cs[15:8] & st[15:8]) != 8'd0) && (st[1] == 1'b0) && (st[0] == 1'b1);
    if (!mem_valid) return 32'h0;
    if (pend) return 32'h1;
    for (int i = 0; i < 5; i++)
      if (flags[i]) return codes[i];
    return 32'h0;
  endfunction

  task automatic check_dut(input int d, input string n, input logic [31:0] t, input logic f,
                           input logic [31:0] np, input logic b, input logic [5:0] io,
                           input logic [31:0] eo, input logic [31:0] ca, input logic ds);
    logic [31:0] et, enp;
    logic [5:0]  eio;
    et  = (rem[d] == 0) ? model_type() : 32'h0;
    enp = (et == 32'h0) ? 32'h0 : ((et == 32'he) ? model_epc() : 32'h20);
`ifdef EXC_INT_SYNC_EN
    eio = {hist1[d][5] | timer_int, hist1[d][4:0]};
`else
    eio = {ext_int[5] | timer_int, ext_int[4:0]};
`endif
    chk({n, ".type"},  t, et);
    chk({n, ".flush"}, {31'd0, f}, {31'd0, et != 32'h0});
    chk({n, ".newpc"}, np, enp);
    chk({n, ".busy"},  {31'd0, b}, {31'd0, rem[d] != 0});
    chk({n, ".int"},   {26'd0, io}, {26'd0, eio});
    chk({n, ".epc"},   eo, model_epc());
    chk({n, ".addr"},  ca, inst_addr);
    chk({n, ".ds"},    {31'd0, ds}, {31'd0, delayslot});
  endtask

  // Check both instances, advance one clock, update the reference
  task automatic cycle();
    #1;
    check_dut(0, "a", type_a, flush_a, npc_a, busy_a, int_a, epc_a, cia_a, ds_a);
    check_dut(1, "b", type_b, flush_b, npc_b, busy_b, int_b, epc_b, cia_b, ds_b);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rem[d] == 0 && model_type() != 32'h0) rem[d] = dcyc[d];
      else if (rem[d] > 0) rem[d] = rem[d] - 1;
      hist1[d] = hist0[d];
      hist0[d] = ext_int;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    mem_valid = 1'b0; flags = 5'd0; wb_we = 1'b0; wb_waddr = 5'd0; wb_data = 32'd0;
    ext_int = 6'd0; timer_int = 1'b0; status = 32'h1000_0001; cause = 32'd0; epc = 32'd0;
    inst_addr = 32'h0; delayslot = 1'b0;
  endtask

  task automatic idle(input int n);
    quiet();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reset_check(input string n, input logic [31:0] t, input logic f,
                             input logic [31:0] np, input logic b, input logic [5:0] io);
    chk({n, ".rst.type"},  t, 32'h0);
    chk({n, ".rst.flush"}, {31'd0, f}, 32'h0);
    chk({n, ".rst.newpc"}, np, 32'h0);
    chk({n, ".rst.busy"},  {31'd0, b}, 32'h0);
    chk({n, ".rst.int"},   {26'd0, io}, 32'h0);
  endtask

  initial begin
    quiet();
    rst = 1'b1; rst3 = 1'b1;
    for (int d = 0; d < 2; d++) begin rem[d] = 0; hist0[d] = 6'd0; hist1[d] = 6'd0; end

    // Reset with aggressive inputs: everything must still read zero
    mem_valid = 1'b1; flags = 5'b00001; ext_int = 6'h3f; timer_int = 1'b1;
    @(negedge clk); #1;
    reset_check("a", type_a, flush_a, npc_a, busy_a, int_a);
    reset_check("b", type_b, flush_b, npc_b, busy_b, int_b);
    @(negedge clk);
    quiet();
    rst = 1'b0; rst3 = 1'b0;
    idle(3);

    // Syscall at 0x100, then one busy cycle on the DRAIN_CYCLES=1 instance
    mem_valid = 1'b1; flags = 5'b00001; inst_addr = 32'h100; status = 32'h1000_0001;
    #1;
    chk("syscall.type", type_a, 32'h8);
    chk("syscall.newpc", npc_a, 32'h20);
    cycle();
    quiet();
    #1; chk("syscall.busy1", {31'd0, busy_a}, 32'h1);
    cycle();
    #1; chk("syscall.busy0", {31'd0, busy_a}, 32'h0);
    idle(3);

    // ERET with a WB mtc0 to EPC in the same cycle
    mem_valid = 1'b1; flags = 5'b10000; epc = 32'h40;
    wb_we = 1'b1; wb_waddr = 5'd14; wb_data = 32'h80;
    #1;
    chk("eret.type", type_a, 32'he);
    chk("eret.newpc", npc_a, 32'h80);
    cycle();
    idle(4);

    // Interrupt on a bubble: no flush; then on a valid instruction
    ext_int = 6'h01; status = 32'h1000_0401; cause = 32'h0000_0400; mem_valid = 1'b0;
    #1; chk("int.bubble.flush", {31'd0, flush_a}, 32'h0);
    cycle();
    mem_valid = 1'b1;
    #1; chk("int.valid.type", type_a, 32'h1);
    cycle();
    idle(4);

    // ov + trap together, then a syscall during drain is dropped
    mem_valid = 1'b1; flags = 5'b01100;
    #1; chk("ovtrap.type", type_a, 32'hd);
    cycle();
    flags = 5'b00001;
    #1; chk("drain.syscall.flush", {31'd0, flush_a}, 32'h0);
    cycle();
    idle(4);

    // rst pulse in the second drain cycle of the DRAIN_CYCLES=3 instance
    mem_valid = 1'b1; flags = 5'b00001;
    cycle();
    quiet();
    cycle();
    mem_valid = 1'b1; flags = 5'b00001;
    #1; chk("b.drain2.busy", {31'd0, busy_b}, 32'h1);
    rst3 = 1'b1;
    #1;
    reset_check("b.mid", type_b, flush_b, npc_b, busy_b, int_b);
    rst3 = 1'b0; rem[1] = 0; hist0[1] = 6'd0; hist1[1] = 6'd0;
    mem_valid = 1'b0;
    cycle();
    idle(4);

    // Interrupt pin latency and the unsynchronized timer line
    ext_int = 6'h08;
`ifdef EXC_INT_SYNC_EN
    #1; chk("sync.edge0", {31'd0, int_a[3]}, 32'h0);
    cycle();
    #1; chk("sync.edge1", {31'd0, int_a[3]}, 32'h0);
    cycle();
    #1; chk("sync.edge2", {31'd0, int_a[3]}, 32'h1);
`else
    #1; chk("comb.int3", {31'd0, int_a[3]}, 32'h1);
`endif
    cycle();
    timer_int = 1'b1;
    #1; chk("timer.int5", {31'd0, int_a[5]}, 32'h1);
    cycle();
    idle(3);

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      mem_valid = ($urandom_range(0, 3) != 0);
      flags     = 5'($urandom) & 5'($urandom);
      inst_addr = $urandom;
      delayslot = 1'($urandom);
      status    = $urandom;
      if ($urandom_range(0, 1) == 1) begin status[1] = 1'b0; status[0] = 1'b1; end
      cause     = $urandom;
      epc       = $urandom;
      wb_we     = 1'($urandom);
      wb_waddr  = 5'($urandom_range(11, 15));
      wb_data   = $urandom;
      ext_int   = 6'($urandom);
      timer_int = 1'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt resolver in the MEM stage. Consumes per-instruction exception flags, the current CP0 Status/Cause/EPC values (with write-back forwarding of in-flight `mtc0`), and the raw external interrupt pins. Produces the interrupt vector, the encoded exception type and the per-instruction context consumed by cp0_reg, plus the pipeline flush and new-PC request consumed by ctrl. A drain state machine prevents the flushed slot from re-triggering before CP0 reflects EXL.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0020: handler entry address for all non-ERET exceptions.
- DRAIN_CYCLES, 1: cycles (1..7) after a taken exception during which no new exception is accepted.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; **asynchronous, active-high**.
- ext_int_i  in  6  raw external interrupt lines, level.
- timer_int_i  in  1  timer interrupt from cp0_reg.
- int_o  out  6  interrupt lines to cp0_reg int_i; bit 5 = ext_int[5] | timer_int_i.
- mem_valid_i  in  1  MEM slot holds a real instruction (0 = bubble).
- mem_exc_flags_i  in  5  {eret, ov, trap, inst_invalid, syscall}.
- mem_inst_addr_i  in  32  MEM instruction address.
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot.
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values.
- wb_cp0_we_i  in  1  WB-stage `mtc0` write enable.
- wb_cp0_waddr_i  in  5  WB CP0 write address.
- wb_cp0_data_i  in  32  WB CP0 write data.
- excepttype_o  out  32  encoded exception to cp0_reg (0 = none).
- current_inst_addr_o  out  32  to cp0_reg.
- is_in_delayslot_o  out  1  to cp0_reg.
- epc_o  out  32  forwarded EPC.
- flush_o  out  1  pipeline flush request to ctrl.
- new_pc_o  out  32  redirect target, valid while flush_o = 1.
- busy_o  out  1  FSM not in IDLE.

## Operation
- Forwarding: effective Status = wb data when wb_cp0_we_i and waddr = CP0_REG_STATUS; otherwise cp0_status_i. Effective EPC: same rule with CP0_REG_EPC. Effective Cause: only bits 9:8, 22 and 23 are taken from wb data; all other bits come from cp0_cause_i.
- Interrupt pending: (Cause[15:8] & Status[15:8]) != 0, Status.EXL (bit 1) = 0 and Status.IE (bit 0) = 1.
- Priority when mem_valid_i = 1 in IDLE: interrupt > syscall > inst_invalid > trap > ov > eret. Encodings: EXCEPTTYPE_INTERRUPT 0x1, SYSCALL 0x8, INST_INVALID 0xa, TRAP 0xd, OV 0xc, ERET 0xe.
- An interrupt is not taken on a bubble (mem_valid_i = 0).
- FSM states:
  - IDLE: when an exception is resolved, drive excepttype_o, set flush_o = 1, load the drain counter with DRAIN_CYCLES, and go to DRAIN.
  - DRAIN: excepttype_o = 0 and flush_o = 0. Decrement the counter each cycle; at 1, return to IDLE.
- new_pc_o: effective EPC for ERET, EXC_VECTOR for everything else; 0 when flush_o = 0.
- current_inst_addr_o and is_in_delayslot_o pass through from the MEM inputs.
- epc_o always carries the effective (forwarded) EPC.

## Timing
- Reset values: excepttype_o 0, flush_o 0, new_pc_o 0, busy_o 0, int_o 0, FSM IDLE, counter 0, synchronizer flops 0.
- Resolution is combinational in the cycle the instruction sits in MEM (0-cycle latency). cp0_reg captures the exception at that cycle's closing edge. busy_o rises the next cycle.
- DRAIN lasts exactly DRAIN_CYCLES cycles. An exception presented during DRAIN is dropped; the pipeline flush guarantees it is a squashed instruction.
- A WB `mtc0` and a MEM exception in the same cycle: the forwarded value decides.
- rst asserted mid-DRAIN: FSM returns to IDLE immediately, with all outputs at their reset values.

## Configuration
- EXC_INT_SYNC_EN defined: ext_int_i passes through a 2-flop synchronizer, so int_o follows the pins with 2 cycles of latency.
- EXC_INT_SYNC_EN undefined: int_o is combinational from ext_int_i (0 latency). Use this only when the pins are already synchronous to clk.
- timer_int_i is never synchronized.

## Structure
- defines.v holds the EXCEPTTYPE_* codes, CP0_REG_* addresses, and the Status bit positions (EXL, IE) and Cause bit positions (IP field, writable bits).
- One sub-module: int_sync, a 6-bit 2-flop synchronizer with asynchronous reset, instantiated only under EXC_INT_SYNC_EN.

## Test plan
- Syscall at addr 0x100, not in delay slot, Status = 0x1000_0001 -> excepttype_o = 0x8, flush_o = 1, new_pc_o = 0x20, then one cycle of busy_o.
- ERET with cp0_epc_i = 0x40 while WB writes EPC = 0x80 in the same cycle -> new_pc_o = 0x80, excepttype_o = 0xe.
- ext_int_i[0] = 1, Status = 0x1000_0401, cp0 Cause[10] = 1, valid instruction -> excepttype_o = 0x1; the same condition on a bubble -> no flush.
- Flags ov and trap set together -> excepttype_o = 0xd. A second syscall on the cycle after the flush (DRAIN) -> ignored, flush_o = 0.
- With DRAIN_CYCLES = 3: rst pulses during the second drain cycle -> all outputs 0 and busy_o = 0 immediately, without waiting for a clock edge.
- With EXC_INT_SYNC_EN: ext_int_i[3] rises -> int_o[3] rises 2 edges later. timer_int_i = 1 -> int_o[5] = 1 in the same cycle.
